// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the ALU sharing controller: operation codes,
// FSM encoding, debug view and the supported-operation filter.
package alu_share_ctrl_pkg;

    localparam logic [5:0] FUNCT_ADDU = 6'b001001;
    localparam logic [5:0] FUNCT_SUBU = 6'b001010;
    localparam logic [5:0] FUNCT_NOR  = 6'b010011;
    localparam logic [5:0] FUNCT_SLTU = 6'b101010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Internal view exported for observation: FSM state, arbitration
    // pointer and the latched operation that is being (or was last) executed.
    typedef struct packed {
        state_t     state;
        logic       ptr;
        logic       id;
        logic [4:0] shamt;
        logic [5:0] funct;
    } dbg_t;

    function automatic logic funct_supported(input logic [5:0] funct);
        case (funct)
            FUNCT_ADDU, FUNCT_SUBU, FUNCT_NOR, FUNCT_SLTU: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Request/response bundle between the two requesters, the response
// consumer and the ALU sharing controller.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. valid must not depend on ready. req_ready is a combinational
// one-hot grant that may rise in the same cycle as req_valid. rsp_valid
// stays high, with rsp_* stable, until the edge where rsp_ready is seen.
interface alu_share_ctrl_if #(
    parameter int DATA_W = 32
);
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [DATA_W-1:0] req0_src1;
    logic [DATA_W-1:0] req0_src2;
    logic [4:0]        req0_shamt;
    logic [5:0]        req0_funct;
    logic [DATA_W-1:0] req1_src1;
    logic [DATA_W-1:0] req1_src2;
    logic [4:0]        req1_shamt;
    logic [5:0]        req1_funct;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_zero;
    logic              rsp_err;
    logic              busy;

    modport master (
        output req_valid, req0_src1, req0_src2, req0_shamt, req0_funct,
               req1_src1, req1_src2, req1_shamt, req1_funct, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, busy
    );

    modport slave (
        input  req_valid, req0_src1, req0_src2, req0_shamt, req0_funct,
               req1_src1, req1_src2, req1_shamt, req1_funct, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, busy
    );

endinterface

// File: rtl/alu_share_ctrl_alu.sv
// Single-cycle ALU shared by both requesters. Purely combinational;
// unknown operation codes yield zero.
module alu_share_ctrl_alu
    import alu_share_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    input  logic [5:0]        funct,
    output logic [DATA_W-1:0] result
);

    // Operation select; add/subtract wrap modulo 2^DATA_W.
    always_comb begin
        result = '0;
        case (funct)
            FUNCT_ADDU: result = src1 + src2;
            FUNCT_SUBU: result = src1 - src2;
            FUNCT_NOR:  result = ~(src1 | src2);
            FUNCT_SLTU: result = {{(DATA_W-1){1'b0}}, (src1 < src2)};
            default:    result = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one ALU between two requesters: round-robin accept,
// one execute cycle, then a held response with valid/ready backpressure.
module alu_share_ctrl
    import alu_share_ctrl_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RR_INIT = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    alu_share_ctrl_if.slave         bus,
    output dbg_t                    dbg
);

    state_t            state_q, state_d;
    logic              ptr_q;
    logic              id_q;
    logic [DATA_W-1:0] src1_q, src2_q;
    logic [4:0]        shamt_q;
    logic [5:0]        funct_q;
    logic              rsp_id_q, rsp_zero_q, rsp_err_q;
    logic [DATA_W-1:0] rsp_result_q;
    logic [DATA_W-1:0] alu_result;
    logic [1:0]        grant;
    logic              accept;

    alu_share_ctrl_alu #(.DATA_W(DATA_W)) u_alu (
        .src1   (src1_q),
        .src2   (src2_q),
        .funct  (funct_q),
        .result (alu_result)
    );

    // Round-robin grant, only offered while idle and out of reset.
    always_comb begin
        grant = 2'b00;
        if (state_q == IDLE && !rst) begin
            if (bus.req_valid == 2'b11) grant = ptr_q ? 2'b10 : 2'b01;
            else                        grant = bus.req_valid;
        end
    end

    assign accept = |(bus.req_valid & grant);

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register and priority pointer; pointer moves past the served requester.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'(RR_INIT);
        end else begin
            state_q <= state_d;
            if (state_q == RESP && bus.rsp_ready) ptr_q <= ~rsp_id_q;
        end
    end

    // Operand latch on the accept edge from the granted requester.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src1_q  <= '0;
            src2_q  <= '0;
            shamt_q <= '0;
            funct_q <= '0;
            id_q    <= 1'b0;
        end else if (accept) begin
            id_q    <= grant[1];
            src1_q  <= grant[1] ? bus.req1_src1  : bus.req0_src1;
            src2_q  <= grant[1] ? bus.req1_src2  : bus.req0_src2;
            shamt_q <= grant[1] ? bus.req1_shamt : bus.req0_shamt;
            funct_q <= grant[1] ? bus.req1_funct : bus.req0_funct;
        end
    end

    // Response capture at the end of EXEC; unsupported codes never use the ALU output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b1;
            rsp_err_q    <= 1'b0;
        end else if (state_q == EXEC) begin
            rsp_id_q <= id_q;
            if (funct_supported(funct_q)) begin
                rsp_result_q <= alu_result;
                rsp_zero_q   <= (alu_result == '0);
                rsp_err_q    <= 1'b0;
            end else begin
                rsp_result_q <= '0;
                rsp_zero_q   <= 1'b1;
                rsp_err_q    <= 1'b1;
            end
        end
    end

    // Outputs decoded from state.
    always_comb begin
        bus.req_ready = grant;
        bus.rsp_valid = (state_q == RESP);
        bus.busy      = (state_q != IDLE);
    end

    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_zero   = rsp_zero_q;
    assign bus.rsp_err    = rsp_err_q;

    assign dbg = '{state: state_q, ptr: ptr_q, id: id_q, shamt: shamt_q, funct: funct_q};

endmodule
